// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, register IDs, datapath width.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package y86_pkg;

    localparam int DATA_W = 64;
    localparam int NREGS  = 15;

    // Register IDs
    localparam logic [3:0] RSP_ID = 4'h4;
    localparam logic [3:0] RNONE  = 4'hF;

    // Instruction codes
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;   // rrmovq / cmovXX
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // True for the twelve defined instruction codes (0..B).
    function automatic logic icode_is_valid(input logic [3:0] icode);
        return (icode <= I_POPQ);
    endfunction

endpackage

// File: rtl/regfile_2r2w.sv
// Program register file: NREGS x DATA_W, two read ports, one debug read, E and M write ports.
// Latency: reads combinational from current state (no bypass); writes commit on rising clk.
// Backpressure: none; writes are accepted every cycle their enable is high.
//
// Ports:
//   clk, rst_n              clock; async active-low clear of every register
//   rd_a_id / rd_a_dat      read port A (ID >= NREGS, incl. RNONE, reads 0)
//   rd_b_id / rd_b_dat      read port B (same rule)
//   dbg_id  / dbg_dat       debug read port (same rule)
//   wr_e_en/_id/_dat        E write port
//   wr_m_en/_id/_dat        M write port; wins over E when both target one register
module regfile_2r2w
    import y86_pkg::*;
#(
    parameter int DATA_W = y86_pkg::DATA_W,
    parameter int NREGS  = y86_pkg::NREGS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        rd_a_id,
    output logic [DATA_W-1:0] rd_a_dat,
    input  logic [3:0]        rd_b_id,
    output logic [DATA_W-1:0] rd_b_dat,
    input  logic [3:0]        dbg_id,
    output logic [DATA_W-1:0] dbg_dat,
    input  logic              wr_e_en,
    input  logic [3:0]        wr_e_id,
    input  logic [DATA_W-1:0] wr_e_dat,
    input  logic              wr_m_en,
    input  logic [3:0]        wr_m_id,
    input  logic [DATA_W-1:0] wr_m_dat
);

    localparam logic [3:0] NREGS_ID = 4'(NREGS);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    // Next-state: E write first, M write second so M overrides E on a
    // shared destination (popq %rsp). IDs outside 0..NREGS-1 match no entry.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_e_en && (wr_e_id == 4'(i))) begin
                regs_d[i] = wr_e_dat;
            end
            if (wr_m_en && (wr_m_id == 4'(i))) begin
                regs_d[i] = wr_m_dat;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Reads see committed state only; RNONE (and any other unmapped ID) reads 0.
    always_comb begin
        rd_a_dat = '0;
        rd_b_dat = '0;
        dbg_dat  = '0;
        if (rd_a_id < NREGS_ID) begin
            rd_a_dat = regs_q[rd_a_id];
        end
        if (rd_b_id < NREGS_ID) begin
            rd_b_dat = regs_q[rd_b_id];
        end
        if (dbg_id < NREGS_ID) begin
            dbg_dat = regs_q[dbg_id];
        end
    end

endmodule

// File: rtl/decode_writeback.sv
// SEQ Y86-64 decode/write-back: register-ID decode, operand read, E/M result commit.
// Latency: decode and operand read combinational; write-back commits on rising clk.
// Backpressure: none; wb_en low suppresses all register updates for that cycle.
//
// Ports:
//   clk, rst_n          clock; async active-low clear of the register file
//   icode, rA, rB       instruction fields from fetch
//   cnd                 execute condition; gates cmovXX E destination
//   valE, valM          execute / memory results written at the edge
//   wb_en               global write enable (low on bad status / invalid instr)
//   srcA, srcB          decoded source IDs; valA, valB their register values
//   dstE, dstM          decoded destination IDs (dstE after cnd gating)
//   dbg_sel / dbg_data  debug register read
module decode_writeback
    import y86_pkg::*;
#(
    parameter int         DATA_W = y86_pkg::DATA_W,
    parameter int         NREGS  = y86_pkg::NREGS,
    parameter logic [3:0] RSP_ID = y86_pkg::RSP_ID
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        icode,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    input  logic              cnd,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valM,
    input  logic              wb_en,
    output logic [3:0]        srcA,
    output logic [3:0]        srcB,
    output logic [3:0]        dstE,
    output logic [3:0]        dstM,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    input  logic [3:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    logic wr_e_en;
    logic wr_m_en;

    // Register-ID decode. Undefined icodes fall through to RNONE on every
    // field, which also makes them write nothing.
    always_comb begin
        srcA = RNONE;
        srcB = RNONE;
        dstE = RNONE;
        dstM = RNONE;

        case (icode)
            I_RRMOVQ: begin
                srcA = rA;
                // cmovXX whose condition fails must not write its destination
                dstE = cnd ? rB : RNONE;
            end
            I_IRMOVQ: begin
                dstE = rB;
            end
            I_RMMOVQ: begin
                srcA = rA;
                srcB = rB;
            end
            I_MRMOVQ: begin
                srcB = rB;
                dstM = rA;
            end
            I_OPQ: begin
                srcA = rA;
                srcB = rB;
                dstE = rB;
            end
            I_CALL: begin
                srcB = RSP_ID;
                dstE = RSP_ID;
            end
            I_RET: begin
                srcA = RSP_ID;
                srcB = RSP_ID;
                dstE = RSP_ID;
            end
            I_PUSHQ: begin
                srcA = rA;
                srcB = RSP_ID;
                dstE = RSP_ID;
            end
            I_POPQ: begin
                srcA = RSP_ID;
                srcB = RSP_ID;
                dstE = RSP_ID;
                dstM = rA;
            end
            default: begin
                // halt, nop, jXX and invalid codes touch no registers
            end
        endcase
    end

    assign wr_e_en = wb_en && (dstE != RNONE) && icode_is_valid(icode);
    assign wr_m_en = wb_en && (dstM != RNONE) && icode_is_valid(icode);

    regfile_2r2w #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_a_id  (srcA),
        .rd_a_dat (valA),
        .rd_b_id  (srcB),
        .rd_b_dat (valB),
        .dbg_id   (dbg_sel),
        .dbg_dat  (dbg_data),
        .wr_e_en  (wr_e_en),
        .wr_e_id  (dstE),
        .wr_e_dat (valE),
        .wr_m_en  (wr_m_en),
        .wr_m_id  (dstM),
        .wr_m_dat (valM)
    );

endmodule

// File: tb/tb_decode_writeback.sv
// Self-checking bench for decode_writeback: directed test-plan steps plus
// randomized instructions against an array-based register model.
module tb_decode_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  icode, rA, rB, dbg_sel;
    logic        cnd, wb_en;
    logic [63:0] valE, valM;
    logic [3:0]  srcA, srcB, dstE, dstM;
    logic [63:0] valA, valB, dbg_data;

    logic [63:0] model [15];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    decode_writeback dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .icode    (icode),
        .rA       (rA),
        .rB       (rB),
        .cnd      (cnd),
        .valE     (valE),
        .valM     (valM),
        .wb_en    (wb_en),
        .srcA     (srcA),
        .srcB     (srcB),
        .dstE     (dstE),
        .dstM     (dstM),
        .valA     (valA),
        .valB     (valB),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference decode straight from the instruction-set table.
    task automatic ref_decode(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                              input logic c, output logic [3:0] sa, output logic [3:0] sb,
                              output logic [3:0] de, output logic [3:0] dm);
        sa = 4'hF; sb = 4'hF; de = 4'hF; dm = 4'hF;
        if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) sa = ra;
        else if (ic inside {4'h9, 4'hB})        sa = 4'h4;
        if (ic inside {4'h4, 4'h5, 4'h6})             sb = rb;
        else if (ic inside {4'h8, 4'h9, 4'hA, 4'hB})  sb = 4'h4;
        if (ic inside {4'h3, 4'h6})                   de = rb;
        else if (ic == 4'h2 && c)                     de = rb;
        else if (ic inside {4'h8, 4'h9, 4'hA, 4'hB})  de = 4'h4;
        if (ic inside {4'h5, 4'hB}) dm = ra;
    endtask

    function automatic logic [63:0] ref_rd(input logic [3:0] id);
        if (id == 4'hF) return 64'h0;
        return model[id];
    endfunction

    // One instruction: drive mid-low-phase, check decode and reads, then let
    // the edge commit and update the model.
    task automatic step(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                        input logic c, input logic [63:0] ve, input logic [63:0] vm,
                        input logic we);
        logic [3:0] sa, sb, de, dm, ds;
        @(negedge clk);
        icode = ic; rA = ra; rB = rb; cnd = c; valE = ve; valM = vm; wb_en = we;
        ds = 4'($urandom_range(0, 15));
        dbg_sel = ds;
        #1;
        ref_decode(ic, ra, rb, c, sa, sb, de, dm);
        chk("srcA", {60'h0, srcA}, {60'h0, sa});
        chk("srcB", {60'h0, srcB}, {60'h0, sb});
        chk("dstE", {60'h0, dstE}, {60'h0, de});
        chk("dstM", {60'h0, dstM}, {60'h0, dm});
        chk("valA", valA, ref_rd(sa));
        chk("valB", valB, ref_rd(sb));
        chk("dbg",  dbg_data, ref_rd(ds));
        @(posedge clk);
        if (rst_n && we) begin
            if (de != 4'hF) model[de] = ve;
            if (dm != 4'hF) model[dm] = vm;   // M applied last: wins on collision
        end
    endtask

    task automatic peek(input string tag, input logic [3:0] id, input logic [63:0] exp);
        dbg_sel = id;
        #1;
        chk(tag, dbg_data, exp);
    endtask

    task automatic sweep_zero(input string tag);
        for (int r = 0; r < 15; r++) begin
            dbg_sel = 4'(r);
            #1;
            chk(tag, dbg_data, 64'h0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        icode = 4'h1; rA = 4'hF; rB = 4'hF; cnd = 1'b0;
        valE = 64'h0; valM = 64'h0; wb_en = 1'b1; dbg_sel = 4'h0;
        for (int r = 0; r < 15; r++) model[r] = 64'h0;

        // Reset: file reads zero during and after reset
        repeat (2) @(posedge clk);
        #1;
        sweep_zero("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        sweep_zero("rst_release");
        peek("rnone_dbg", 4'hF, 64'h0);

        // irmovq $0x100, %rsp
        step(4'h3, 4'hF, 4'h4, 1'b0, 64'h100, 64'h0, 1'b1);
        #1;
        chk("irmov_dstE", {60'h0, dstE}, 64'h4);
        chk("irmov_srcA", {60'h0, srcA}, 64'hF);
        chk("irmov_srcB", {60'h0, srcB}, 64'hF);
        peek("irmov_r4", 4'h4, 64'h100);

        // OPq with r2=5, r3=7
        step(4'h3, 4'hF, 4'h2, 1'b0, 64'd5, 64'h0, 1'b1);
        step(4'h3, 4'hF, 4'h3, 1'b0, 64'd7, 64'h0, 1'b1);
        step(4'h6, 4'h2, 4'h3, 1'b0, 64'd12, 64'h0, 1'b1);
        #1;
        chk("opq_dstE", {60'h0, dstE}, 64'h3);
        chk("opq_valA", valA, 64'd5);
        peek("opq_r3", 4'h3, 64'd12);

        // cmov gating
        step(4'h3, 4'hF, 4'h1, 1'b0, 64'h11, 64'h0, 1'b1);
        step(4'h2, 4'h1, 4'h6, 1'b0, 64'h11, 64'h0, 1'b1);
        #1;
        chk("cmov0_dstE", {60'h0, dstE}, 64'hF);
        peek("cmov0_r6", 4'h6, 64'h0);
        step(4'h2, 4'h1, 4'h6, 1'b1, 64'h11, 64'h0, 1'b1);
        #1;
        chk("cmov1_dstE", {60'h0, dstE}, 64'h6);
        peek("cmov1_r6", 4'h6, 64'h11);

        // popq %rsp: M beats E
        step(4'hB, 4'h4, 4'hF, 1'b0, 64'h108, 64'hDEAD, 1'b1);
        peek("popq_rsp", 4'h4, 64'hDEAD);

        // wb_en low blocks the write
        step(4'h3, 4'hF, 4'h1, 1'b0, 64'd9, 64'h0, 1'b0);
        peek("wben0_r1", 4'h1, 64'h11);

        // Randomized instructions, all icodes including invalid ones
        for (int n = 0; n < 300; n++) begin
            logic [3:0] pr;
            step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
                 ($urandom_range(0, 7) != 0));
            pr = 4'($urandom_range(0, 15));
            peek("rand_dbg", pr, ref_rd(pr));
        end

        // Fill a register, then reset mid-cycle with a write pending
        step(4'h3, 4'hF, 4'h5, 1'b0, 64'hCAFE, 64'h0, 1'b1);
        peek("pre_rst_r5", 4'h5, 64'hCAFE);
        @(negedge clk);
        #2;
        icode = 4'h3; rA = 4'hF; rB = 4'h7; valE = 64'h777; wb_en = 1'b1;
        rst_n = 1'b0;
        for (int r = 0; r < 15; r++) model[r] = 64'h0;
        sweep_zero("midrst");
        @(posedge clk);
        #1;
        peek("midrst_r7", 4'h7, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 20; n++) begin
            step(4'($urandom_range(0, 11)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
